// File: rtl/cmd_link_pkg.sv
// Shared types and defaults for the two-byte command link.
// Used by the remote endpoint and its UART transceiver.
package cmd_link_pkg;

    typedef enum logic {
        WAIT_HI,
        WAIT_LO
    } rx_state_t;

    typedef enum logic {
        IDLE,
        BUSY
    } tx_state_t;

    localparam int DEF_BAUD_DIV    = 2604;
    localparam int DEF_TIMEOUT_CYC = 1_000_000;
    localparam int CMD_W           = 16;
    localparam int BYTE_W          = 8;

endpackage

// File: rtl/uart_xcvr.sv
// 8N1 UART transceiver, LSB first, BAUD_DIV clocks per bit.
// RX is double-flopped and sampled mid-bit; rx_rdy fires at mid-stop.
module uart_xcvr
    import cmd_link_pkg::*;
#(
    parameter int BAUD_DIV = DEF_BAUD_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RX,
    output logic              TX,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              trmt,
    output logic              tx_done,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_rdy,
    input  logic              clr_rx_rdy
);

    localparam int            CW        = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
    localparam logic [3:0]    LAST_IDX  = 4'd9;

    logic              r_rx_s1;
    logic              r_rx_s2;
    logic              r_rx_busy;
    logic              r_rx_rdy;
    logic [CW-1:0]     r_rx_cnt;
    logic [3:0]        r_rx_idx;
    logic [BYTE_W-1:0] r_rx_sh;

    logic              r_tx;
    logic              r_tx_busy;
    logic              r_tx_done;
    logic [CW-1:0]     r_tx_cnt;
    logic [3:0]        r_tx_idx;
    logic [BYTE_W:0]   r_tx_sh;

    // idx 0 is the start-bit check, 1..8 data, 9 the stop bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_busy <= 1'b0;
            r_rx_rdy  <= 1'b0;
            r_rx_cnt  <= '0;
            r_rx_idx  <= '0;
            r_rx_sh   <= '0;
        end else begin
            r_rx_s1 <= RX;
            r_rx_s2 <= r_rx_s1;
            if (clr_rx_rdy) begin
                r_rx_rdy <= 1'b0;
            end
            if (!r_rx_busy) begin
                if (!r_rx_s2) begin
                    r_rx_busy <= 1'b1;
                    r_rx_cnt  <= HALF_LAST;
                    r_rx_idx  <= '0;
                end
            end else if (r_rx_cnt != '0) begin
                r_rx_cnt <= r_rx_cnt - 1'b1;
            end else begin
                r_rx_cnt <= BIT_LAST;
                r_rx_idx <= r_rx_idx + 4'd1;
                if (r_rx_idx == '0) begin
                    if (r_rx_s2) begin
                        r_rx_busy <= 1'b0;
                    end
                end else if (r_rx_idx == LAST_IDX) begin
                    r_rx_busy <= 1'b0;
                    if (r_rx_s2) begin
                        r_rx_rdy <= 1'b1;
                    end
                end else begin
                    r_rx_sh <= {r_rx_s2, r_rx_sh[BYTE_W-1:1]};
                end
            end
        end
    end

    // shift register carries {stop, data}; start bit is driven on load
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx      <= 1'b1;
            r_tx_busy <= 1'b0;
            r_tx_done <= 1'b0;
            r_tx_cnt  <= '0;
            r_tx_idx  <= '0;
            r_tx_sh   <= '1;
        end else begin
            r_tx_done <= 1'b0;
            if (!r_tx_busy) begin
                if (trmt) begin
                    r_tx_busy <= 1'b1;
                    r_tx      <= 1'b0;
                    r_tx_sh   <= {1'b1, tx_data};
                    r_tx_cnt  <= BIT_LAST;
                    r_tx_idx  <= '0;
                end
            end else if (r_tx_cnt != '0) begin
                r_tx_cnt <= r_tx_cnt - 1'b1;
            end else if (r_tx_idx == LAST_IDX) begin
                r_tx_busy <= 1'b0;
                r_tx_done <= 1'b1;
                r_tx      <= 1'b1;
            end else begin
                r_tx     <= r_tx_sh[0];
                r_tx_sh  <= {1'b1, r_tx_sh[BYTE_W:1]};
                r_tx_idx <= r_tx_idx + 4'd1;
                r_tx_cnt <= BIT_LAST;
            end
        end
    end

    assign TX      = r_tx;
    assign tx_done = r_tx_done;
    assign rx_data = r_rx_sh;
    assign rx_rdy  = r_rx_rdy;

endmodule

// File: rtl/cmd_rx_wrapper.sv
// Remote command endpoint: assembles two RX bytes into a command
// word and sends one response byte back over the same UART.
module cmd_rx_wrapper
    import cmd_link_pkg::*;
#(
    parameter int BAUD_DIV    = DEF_BAUD_DIV,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RX,
    output logic              TX,
    output logic [CMD_W-1:0]  cmd,
    output logic              cmd_rdy,
    input  logic              clr_cmd_rdy,
    output logic              cmd_timeout,
    input  logic [BYTE_W-1:0] resp,
    input  logic              send_resp,
    output logic              resp_sent
);

    localparam int            TW       = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [BYTE_W-1:0] w_rx_data;
    logic              w_rx_rdy;
    logic              w_tx_done;

    rx_state_t         r_rx_st;
    rx_state_t         w_rx_st_nxt;
    logic [BYTE_W-1:0] r_hi;
    logic [BYTE_W-1:0] w_hi_nxt;
    logic [CMD_W-1:0]  r_cmd;
    logic [CMD_W-1:0]  w_cmd_nxt;
    logic              r_cmd_rdy;
    logic              w_cmd_rdy_nxt;
    logic              r_tmo;
    logic              w_tmo_nxt;
    logic [TW-1:0]     r_cnt;
    logic [TW-1:0]     w_cnt_nxt;

    tx_state_t         r_tx_st;
    tx_state_t         w_tx_st_nxt;
    logic [BYTE_W-1:0] r_resp;
    logic [BYTE_W-1:0] w_resp_nxt;
    logic              r_trmt;
    logic              w_trmt_nxt;
    logic              r_sent;
    logic              w_sent_nxt;

    uart_xcvr #(
        .BAUD_DIV(BAUD_DIV)
    ) u_xcvr (
        .clk       (clk),
        .rst       (rst),
        .RX        (RX),
        .TX        (TX),
        .tx_data   (r_resp),
        .trmt      (r_trmt),
        .tx_done   (w_tx_done),
        .rx_data   (w_rx_data),
        .rx_rdy    (w_rx_rdy),
        .clr_rx_rdy(w_rx_rdy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_st   <= WAIT_HI;
            r_hi      <= '0;
            r_cmd     <= '0;
            r_cmd_rdy <= 1'b0;
            r_tmo     <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_rx_st   <= w_rx_st_nxt;
            r_hi      <= w_hi_nxt;
            r_cmd     <= w_cmd_nxt;
            r_cmd_rdy <= w_cmd_rdy_nxt;
            r_tmo     <= w_tmo_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    // a byte arriving on the timeout cycle completes the command
    always_comb begin
        w_rx_st_nxt   = r_rx_st;
        w_hi_nxt      = r_hi;
        w_cmd_nxt     = r_cmd;
        w_cmd_rdy_nxt = r_cmd_rdy & ~clr_cmd_rdy;
        w_tmo_nxt     = 1'b0;
        w_cnt_nxt     = r_cnt;
        unique case (r_rx_st)
            WAIT_HI: begin
                if (w_rx_rdy) begin
                    w_hi_nxt      = w_rx_data;
                    w_cmd_rdy_nxt = 1'b0;
                    w_cnt_nxt     = '0;
                    w_rx_st_nxt   = WAIT_LO;
                end
            end
            WAIT_LO: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_rx_rdy) begin
                    w_cmd_nxt     = {r_hi, w_rx_data};
                    w_cmd_rdy_nxt = 1'b1;
                    w_rx_st_nxt   = WAIT_HI;
                end else if (r_cnt == TMO_LAST) begin
                    w_tmo_nxt   = 1'b1;
                    w_rx_st_nxt = WAIT_HI;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_st <= IDLE;
            r_resp  <= '0;
            r_trmt  <= 1'b0;
            r_sent  <= 1'b0;
        end else begin
            r_tx_st <= w_tx_st_nxt;
            r_resp  <= w_resp_nxt;
            r_trmt  <= w_trmt_nxt;
            r_sent  <= w_sent_nxt;
        end
    end

    always_comb begin
        w_tx_st_nxt = r_tx_st;
        w_resp_nxt  = r_resp;
        w_trmt_nxt  = 1'b0;
        w_sent_nxt  = r_sent;
        unique case (r_tx_st)
            IDLE: begin
                if (send_resp) begin
                    w_resp_nxt  = resp;
                    w_trmt_nxt  = 1'b1;
                    w_sent_nxt  = 1'b0;
                    w_tx_st_nxt = BUSY;
                end
            end
            BUSY: begin
                if (w_tx_done) begin
                    w_sent_nxt  = 1'b1;
                    w_tx_st_nxt = IDLE;
                end
            end
        endcase
    end

    assign cmd         = r_cmd;
    assign cmd_rdy     = r_cmd_rdy;
    assign cmd_timeout = r_tmo;
    assign resp_sent   = r_sent;

endmodule

// File: tb/tb_cmd_rx_wrapper.sv
// Scoreboard bench for cmd_rx_wrapper: serial stimulus on RX/resp,
// monitors decode cmd_rdy rises and TX frames against queued expectations.
module tb_cmd_rx_wrapper;

    localparam int BD  = 16;
    localparam int TMO = 400;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RX = 1'b1;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        cmd_timeout;
    logic        resp_sent;

    always #5 clk = ~clk;

    cmd_rx_wrapper #(
        .BAUD_DIV   (BD),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RX         (RX),
        .TX         (TX),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .cmd_timeout(cmd_timeout),
        .resp       (resp),
        .send_resp  (send_resp),
        .resp_sent  (resp_sent)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_cmd[$];
    logic [7:0]  exp_tx[$];

    logic rst_q = 1'b1;
    int   cyc = 0;
    always @(posedge clk) begin
        rst_q <= rst;
        cyc   <= cyc + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act,
                           input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    // timeout pulse monitor
    int   tmo_cnt = 0;
    int   tmo_last = 0;
    logic tmo_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst_q && cmd_timeout) begin
            tmo_cnt++;
            tmo_last = cyc;
            chk("tmo_one_cycle", {31'b0, tmo_prev}, 0);
        end
        tmo_prev = cmd_timeout;
    end

    // command monitor: each cmd_rdy rise pops one expected command
    logic        rdy_prev = 1'b0;
    logic [15:0] cmd_prev = 16'h0;
    always @(negedge clk) begin
        if (rst_q) begin
            rdy_prev = 1'b0;
            cmd_prev = cmd;
        end else begin
            if (cmd_rdy && !rdy_prev) begin
                if (exp_cmd.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL cmd_unexpected: got %h expected none", cmd);
                end else begin
                    chk("cmd_value", cmd, exp_cmd.pop_front());
                end
            end else if (cmd !== cmd_prev) begin
                chk("cmd_stable", cmd, cmd_prev);
            end
            rdy_prev = cmd_rdy;
            cmd_prev = cmd;
        end
    end

    // TX frame decoder; a reset during a frame abandons it
    initial begin : txmon
        logic [7:0] b;
        logic       ab;
        logic       stp;
        forever begin
            @(negedge clk);
            if (!rst_q && TX === 1'b0) begin
                ab  = 1'b0;
                b   = 8'h00;
                stp = 1'b0;
                for (int k = 0; k < BD / 2 - 1 && !ab; k++) begin
                    @(negedge clk);
                    if (rst_q) ab = 1'b1;
                end
                if (!ab) chk("tx_start_bit", {31'b0, TX}, 0);
                for (int i = 0; i < 9 && !ab; i++) begin
                    for (int k = 0; k < BD && !ab; k++) begin
                        @(negedge clk);
                        if (rst_q) ab = 1'b1;
                    end
                    if (i < 8) b[i] = TX;
                    else stp = TX;
                end
                if (!ab) begin
                    chk("tx_stop_bit", {31'b0, stp}, 1);
                    if (exp_tx.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL tx_unexpected: got %h expected none", b);
                    end else begin
                        chk("tx_byte", b, exp_tx.pop_front());
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        RX = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BD) @(negedge clk);
        end
        RX = 1'b1;
        repeat (BD) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [15:0] c, input int gap);
        exp_cmd.push_back(c);
        send_byte(c[15:8]);
        repeat (gap) @(negedge clk);
        send_byte(c[7:0]);
    endtask

    task automatic send_rsp(input logic [7:0] b, input bit dup);
        int lat;
        int t0;
        t0 = cyc;
        resp = b;
        send_resp = 1'b1;
        exp_tx.push_back(b);
        @(negedge clk);
        send_resp = 1'b0;
        resp = 8'($urandom);
        chk("resp_sent_clr", {31'b0, resp_sent}, 0);
        lat = 1;
        while (TX !== 1'b0 && lat < 6) begin
            @(negedge clk);
            lat++;
        end
        chk_rng("tx_start_latency", lat, 1, 2);
        if (dup) begin
            repeat (40) @(negedge clk);
            resp = 8'hFF;
            send_resp = 1'b1;
            @(negedge clk);
            send_resp = 1'b0;
        end
        while (resp_sent !== 1'b1 && cyc - t0 < 10 * BD + 20) @(negedge clk);
        chk("resp_sent_set", {31'b0, resp_sent}, 1);
        chk_rng("resp_sent_latency", cyc - t0, 10 * BD, 10 * BD + 5);
    endtask

    initial begin : stim
        logic [15:0] c_before;
        int          t0;
        int          tc;
        int          k;

        repeat (4) @(negedge clk);
        chk("rst_TX", {31'b0, TX}, 1);
        chk("rst_cmd", cmd, 0);
        chk("rst_cmd_rdy", {31'b0, cmd_rdy}, 0);
        chk("rst_cmd_timeout", {31'b0, cmd_timeout}, 0);
        chk("rst_resp_sent", {31'b0, resp_sent}, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // basic command and consumer handshake
        send_cmd(16'hA53C, 0);
        chk("t1_cmd", cmd, 16'hA53C);
        chk("t1_rdy", {31'b0, cmd_rdy}, 1);
        repeat (20) @(negedge clk);
        chk("t1_rdy_hold", {31'b0, cmd_rdy}, 1);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        chk("t1_rdy_clr", {31'b0, cmd_rdy}, 0);

        // partial command times out
        c_before = cmd;
        send_byte(8'h12);
        t0 = cyc;
        tc = tmo_cnt;
        repeat (TMO + 80) @(negedge clk);
        chk("t2_tmo_count", tmo_cnt - tc, 1);
        chk_rng("t2_tmo_time", tmo_last - t0, TMO - 20, TMO + 10);
        chk("t2_cmd_kept", cmd, c_before);
        chk("t2_rdy", {31'b0, cmd_rdy}, 0);
        send_cmd(16'h5678, 2);
        chk("t2_cmd_new", cmd, 16'h5678);

        // response frame, with an ignored second request mid-frame
        send_rsp(8'hC3, 1'b1);
        repeat (30) @(negedge clk);

        // back-to-back commands without consumer
        send_cmd(16'h0102, 0);
        exp_cmd.push_back(16'h0304);
        send_byte(8'h03);
        chk("t4_rdy_drop", {31'b0, cmd_rdy}, 0);
        chk("t4_cmd_old", cmd, 16'h0102);
        send_byte(8'h04);
        chk("t4_cmd_new", cmd, 16'h0304);

        // clear coinciding with completion: set wins
        exp_cmd.push_back(16'h4D2B);
        send_byte(8'h4D);
        clr_cmd_rdy = 1'b1;
        fork
            send_byte(8'h2B);
            begin
                k = 0;
                while (cmd_rdy !== 1'b1 && k < 12 * BD) begin
                    @(negedge clk);
                    k++;
                end
                clr_cmd_rdy = 1'b0;
            end
        join
        chk("t6_rdy_set_wins", {31'b0, cmd_rdy}, 1);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;

        // full duplex
        fork
            send_cmd(16'h9A7E, 3);
            begin
                repeat (20) @(negedge clk);
                send_rsp(8'h5B, 1'b0);
            end
        join
        chk("t6_duplex_cmd", cmd, 16'h9A7E);

        // randomized traffic
        tc = tmo_cnt;
        fork
            for (int n = 0; n < 12; n++) begin
                send_cmd(16'($urandom), $urandom_range(0, 40));
                repeat ($urandom_range(0, 20)) @(negedge clk);
            end
            for (int n = 0; n < 5; n++) begin
                repeat ($urandom_range(5, 60)) @(negedge clk);
                send_rsp(8'($urandom), 1'b0);
            end
            for (int n = 0; n < 40; n++) begin
                repeat ($urandom_range(10, 80)) @(negedge clk);
                clr_cmd_rdy = 1'b1;
                @(negedge clk);
                clr_cmd_rdy = 1'b0;
            end
        join
        chk("rand_no_tmo", tmo_cnt - tc, 0);
        repeat (30) @(negedge clk);

        // reset mid low byte and mid TX frame
        send_byte(8'h11);
        fork
            begin
                RX = 1'b0;
                repeat (4 * BD) @(negedge clk);
            end
            begin
                repeat (4) @(negedge clk);
                resp = 8'h00;
                send_resp = 1'b1;
                @(negedge clk);
                send_resp = 1'b0;
            end
        join
        chk("t5_tx_low_pre", {31'b0, TX}, 0);
        rst = 1'b1;
        RX = 1'b1;
        @(negedge clk);
        chk("t5_TX", {31'b0, TX}, 1);
        chk("t5_cmd", cmd, 0);
        chk("t5_cmd_rdy", {31'b0, cmd_rdy}, 0);
        chk("t5_cmd_timeout", {31'b0, cmd_timeout}, 0);
        chk("t5_resp_sent", {31'b0, resp_sent}, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        send_cmd(16'hBEEF, 5);
        chk("t5_cmd_after", cmd, 16'hBEEF);

        repeat (50) @(negedge clk);
        chk("cmd_queue_empty", exp_cmd.size(), 0);
        chk("tx_queue_empty", exp_tx.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
